// File: rtl/prf_pkg.sv
// Shared types and default sizing for the physical register file.
// Bypass forwarding is enabled by defining PRF_BYPASS_EN.
package prf_pkg;

  localparam int unsigned DEF_NUM_PREGS = 64;
  localparam int unsigned DEF_DATA_W    = 32;
  localparam int unsigned DEF_TAG_W     = $clog2(DEF_NUM_PREGS);

  typedef logic [DEF_TAG_W-1:0]  ptag_t;
  typedef logic [DEF_DATA_W-1:0] pdata_t;

  // p0 is the architectural zero register: always 0, always ready
  localparam int unsigned PREG_ZERO = 0;

endpackage

// File: rtl/prf_wr_arbiter.sv
// Highest-index-wins selection among CDB write ports for one target tag.
// Used per register for array writes and per read port for bypass.
module prf_wr_arbiter
  import prf_pkg::*;
#(
  parameter int unsigned NUM_WR = 2,
  parameter int unsigned TAG_W  = DEF_TAG_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic [TAG_W-1:0]         i_tag,
  input  logic [NUM_WR-1:0]        i_wr_valid,
  input  logic [NUM_WR*TAG_W-1:0]  i_wr_tag,
  input  logic [NUM_WR*DATA_W-1:0] i_wr_data,
  output logic                     o_hit_c,
  output logic [DATA_W-1:0]        o_data_c,
  output logic                     o_multi_c
);

  // Later ports overwrite earlier ones; a second hit flags a collision
  always_comb begin
    o_hit_c   = 1'b0;
    o_data_c  = '0;
    o_multi_c = 1'b0;
    for (int j = 0; j < int'(NUM_WR); j++) begin
      if (i_wr_valid[j] && (i_wr_tag[j*TAG_W +: TAG_W] == i_tag)) begin
        o_multi_c = o_multi_c | o_hit_c;
        o_hit_c   = 1'b1;
        o_data_c  = i_wr_data[j*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/prf_multiport.sv
// Multi-ported physical register file with per-register ready bits.
// Optional same-cycle CDB forwarding to read ports under PRF_BYPASS_EN.
module prf_multiport
  import prf_pkg::*;
#(
  parameter  int unsigned NUM_PREGS = DEF_NUM_PREGS,
  parameter  int unsigned DATA_W    = DEF_DATA_W,
  parameter  int unsigned NUM_RD    = 2,
  parameter  int unsigned NUM_WR    = 2,
  localparam int unsigned TAG_W     = $clog2(NUM_PREGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*TAG_W-1:0]  rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_ready,
  input  logic [NUM_WR-1:0]        wr_valid,
  input  logic [NUM_WR*TAG_W-1:0]  wr_tag,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     alloc_valid,
  input  logic [TAG_W-1:0]         alloc_tag,
  output logic                     wr_conflict
);

  logic [DATA_W-1:0]    r_data [NUM_PREGS];
  logic [NUM_PREGS-1:0] r_ready;
  logic                 r_conflict;

  logic [NUM_PREGS-1:1] w_we;
  logic [NUM_PREGS-1:1] w_multi;
  logic [DATA_W-1:0]    w_wdata [NUM_PREGS-1:1];

  // Per-register write select; p0 has no write path at all
  for (genvar p = 1; p < NUM_PREGS; p++) begin : g_wsel
    prf_wr_arbiter #(
      .NUM_WR (NUM_WR),
      .TAG_W  (TAG_W),
      .DATA_W (DATA_W)
    ) u_wsel (
      .i_tag      (TAG_W'(p)),
      .i_wr_valid (wr_valid),
      .i_wr_tag   (wr_tag),
      .i_wr_data  (wr_data),
      .o_hit_c    (w_we[p]),
      .o_data_c   (w_wdata[p]),
      .o_multi_c  (w_multi[p])
    );
  end

  // Array update: alloc clear is applied after writeback so it wins the ready bit
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < int'(NUM_PREGS); p++) begin
        r_data[p]  <= '0;
        r_ready[p] <= 1'b1;
      end
      r_conflict <= 1'b0;
    end else begin
      for (int p = 1; p < int'(NUM_PREGS); p++) begin
        if (w_we[p]) begin
          r_data[p]  <= w_wdata[p];
          r_ready[p] <= 1'b1;
        end
        if (alloc_valid && (alloc_tag == TAG_W'(p))) begin
          r_ready[p] <= 1'b0;
        end
      end
      r_conflict <= |w_multi;
    end
  end

  assign wr_conflict = r_conflict;

  // Combinational read ports
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [TAG_W-1:0]  w_addr;
    logic              w_is_zero;
    logic              w_fwd;
    logic [DATA_W-1:0] w_fwd_data;

    assign w_addr    = rd_addr[i*TAG_W +: TAG_W];
    assign w_is_zero = (w_addr == TAG_W'(PREG_ZERO));

`ifdef PRF_BYPASS_EN
    logic w_byp_unused;

    prf_wr_arbiter #(
      .NUM_WR (NUM_WR),
      .TAG_W  (TAG_W),
      .DATA_W (DATA_W)
    ) u_byp (
      .i_tag      (w_addr),
      .i_wr_valid (wr_valid),
      .i_wr_tag   (wr_tag),
      .i_wr_data  (wr_data),
      .o_hit_c    (w_fwd),
      .o_data_c   (w_fwd_data),
      .o_multi_c  (w_byp_unused)
    );
`else
    assign w_fwd      = 1'b0;
    assign w_fwd_data = '0;
`endif

    assign rd_data[i*DATA_W +: DATA_W] = w_is_zero ? '0 :
                                         (w_fwd ? w_fwd_data : r_data[w_addr]);
    assign rd_ready[i] = w_is_zero | w_fwd | r_ready[w_addr];
  end

endmodule

// File: tb/tb_prf_multiport.sv
// Self-checking bench for prf_multiport: directed vector table, hand sequences
// and randomized traffic checked against an array-based reference model.
module tb_prf_multiport;
  import prf_pkg::*;

  localparam int unsigned NP = 64;
  localparam int unsigned DW = 32;
  localparam int unsigned TW = 6;
  localparam int unsigned NR = 2;
  localparam int unsigned NW = 2;

  logic clk = 1'b0;
  logic rst;
  logic [NR-1:0][TW-1:0] ra;
  logic [NR-1:0][DW-1:0] rdd;
  logic [NR-1:0]         rdy;
  logic [NW-1:0]         wv;
  logic [NW-1:0][TW-1:0] wt;
  logic [NW-1:0][DW-1:0] wd;
  logic                  av;
  logic [TW-1:0]         at;
  logic                  conf;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_data  [NP];
  logic          m_ready [NP];
  logic          m_conf;

  always #5 clk = ~clk;

  prf_multiport dut (
    .clk         (clk),
    .rst         (rst),
    .rd_addr     (ra),
    .rd_data     (rdd),
    .rd_ready    (rdy),
    .wr_valid    (wv),
    .wr_tag      (wt),
    .wr_data     (wd),
    .alloc_valid (av),
    .alloc_tag   (at),
    .wr_conflict (conf)
  );

  typedef struct {
    logic          rst;
    logic [1:0]    wv;
    logic [TW-1:0] wt0, wt1;
    logic [DW-1:0] wd0, wd1;
    logic          av;
    logic [TW-1:0] at;
    logic [TW-1:0] ra0, ra1;
    logic [DW-1:0] ed0, ed1;
    logic          er0, er1, ec;
  } vec_t;

  vec_t vecs [11];

  function automatic vec_t mkv(
    input logic r, input logic [1:0] v, input int t0, input int t1,
    input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic a, input int atg,
    input int r0, input int r1, input logic [DW-1:0] e0, input logic y0,
    input logic [DW-1:0] e1, input logic y1, input logic c);
    vec_t x;
    x.rst = r; x.wv = v; x.wt0 = TW'(t0); x.wt1 = TW'(t1);
    x.wd0 = d0; x.wd1 = d1; x.av = a; x.at = TW'(atg);
    x.ra0 = TW'(r0); x.ra1 = TW'(r1);
    x.ed0 = e0; x.er0 = y0; x.ed1 = e1; x.er1 = y1; x.ec = c;
    return x;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: highest write port wins, p0 immune, alloc clears ready last
  task automatic tick();
    logic [DW-1:0] nd [NP];
    logic          nr [NP];
    logic          nc;
    nd = m_data;
    nr = m_ready;
    nc = 1'b0;
    if (rst) begin
      for (int p = 0; p < int'(NP); p++) begin
        nd[p] = '0;
        nr[p] = 1'b1;
      end
    end else begin
      for (int j = 0; j < int'(NW); j++)
        if (wv[j] && wt[j] != '0) begin
          nd[wt[j]] = wd[j];
          nr[wt[j]] = 1'b1;
        end
      for (int j = 0; j < int'(NW); j++)
        for (int k = j + 1; k < int'(NW); k++)
          if (wv[j] && wv[k] && wt[j] == wt[k] && wt[j] != '0) nc = 1'b1;
      if (av && at != '0) nr[at] = 1'b0;
    end
    @(posedge clk);
    #1;
    m_data  = nd;
    m_ready = nr;
    m_conf  = nc;
  endtask

  function automatic void exp_read(input logic [TW-1:0] a, output logic [DW-1:0] d, output logic r);
    if (a == '0) begin
      d = '0;
      r = 1'b1;
    end else begin
      d = m_data[a];
      r = m_ready[a];
`ifdef PRF_BYPASS_EN
      for (int j = 0; j < int'(NW); j++)
        if (wv[j] && wt[j] == a) begin
          d = wd[j];
          r = 1'b1;
        end
`endif
    end
  endfunction

  task automatic chk_model_reads(input string tag);
    logic [DW-1:0] d;
    logic          r;
    for (int i = 0; i < int'(NR); i++) begin
      exp_read(ra[i], d, r);
      chk($sformatf("%s rd_data[%0d] tag %0d", tag, i, ra[i]), rdd[i], d);
      chk($sformatf("%s rd_ready[%0d] tag %0d", tag, i, ra[i]), DW'(rdy[i]), DW'(r));
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; wv = '0; wt = '0; wd = '0; av = 1'b0; at = '0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    pdata_t exp_d;
    logic   exp_r;

    idle_inputs();
    rst = 1'b1;
    ra  = '0;

    vecs[0]  = mkv(1, 2'b11,  5,  9, 32'hAA,       32'hBB,       1, 63,  5, 63, 0,            1, 0,            1, 0);
    vecs[1]  = mkv(0, 2'b00,  0,  0, 0,            0,            0,  0,  0, 63, 0,            1, 0,            1, 0);
    vecs[2]  = mkv(0, 2'b00,  0,  0, 0,            0,            1,  7,  7,  5, 0,            0, 0,            1, 0);
    vecs[3]  = mkv(0, 2'b01,  7,  0, 32'hDEADBEEF, 0,            0,  0,  7,  7, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1, 0);
    vecs[4]  = mkv(0, 2'b11,  9,  9, 32'h11,       32'h22,       0,  0,  9,  7, 32'h22,       1, 32'hDEADBEEF, 1, 1);
    vecs[5]  = mkv(0, 2'b00,  0,  0, 0,            0,            0,  0,  9,  9, 32'h22,       1, 32'h22,       1, 0);
    vecs[6]  = mkv(0, 2'b11,  0,  0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1,  0,  0,  0, 0,            1, 0,            1, 0);
    vecs[7]  = mkv(0, 2'b10,  0, 12, 0,            32'h5A,       1, 12, 12,  0, 32'h5A,       0, 0,            1, 0);
    vecs[8]  = mkv(0, 2'b11, 21, 21, 32'h99,       32'h77,       0,  0, 21, 12, 32'h77,       1, 32'h5A,       0, 1);
    vecs[9]  = mkv(1, 2'b11, 30, 30, 32'h1,        32'h2,        1, 30, 21, 30, 0,            1, 0,            1, 0);
    vecs[10] = mkv(0, 2'b00,  0,  0, 0,            0,            0,  0, 12, 63, 0,            1, 0,            1, 0);

    // Directed table: one stimulus cycle, then idle inputs and check the result
    for (int n = 0; n < 11; n++) begin
      rst = vecs[n].rst; wv = vecs[n].wv;
      wt[0] = vecs[n].wt0; wt[1] = vecs[n].wt1;
      wd[0] = vecs[n].wd0; wd[1] = vecs[n].wd1;
      av = vecs[n].av; at = vecs[n].at;
      tick();
      idle_inputs();
      ra[0] = vecs[n].ra0;
      ra[1] = vecs[n].ra1;
      #1;
      chk($sformatf("vec%0d rd_data[0]", n), rdd[0], vecs[n].ed0);
      chk($sformatf("vec%0d rd_ready[0]", n), DW'(rdy[0]), DW'(vecs[n].er0));
      chk($sformatf("vec%0d rd_data[1]", n), rdd[1], vecs[n].ed1);
      chk($sformatf("vec%0d rd_ready[1]", n), DW'(rdy[1]), DW'(vecs[n].er1));
      chk($sformatf("vec%0d wr_conflict", n), DW'(conf), DW'(vecs[n].ec));
    end

    // Same-cycle read of a tag being written (all registers reset-clean here)
    wv = 2'b01; wt[0] = TW'(20); wd[0] = 32'h1234;
    ra[0] = TW'(20); ra[1] = TW'(20);
    #1;
`ifdef PRF_BYPASS_EN
    exp_d = 32'h1234; exp_r = 1'b1;
`else
    exp_d = 32'h0;    exp_r = 1'b1;
`endif
    chk("bypass same-cycle rd_data[0]", rdd[0], exp_d);
    chk("bypass same-cycle rd_ready[1]", DW'(rdy[1]), DW'(exp_r));
    tick();
    idle_inputs();
    #1;
    chk("write visible next cycle rd_data[1]", rdd[1], 32'h1234);
    chk("write visible next cycle rd_ready[0]", DW'(rdy[0]), 32'd1);

    // Collision plus alloc on the tag being read; bypass ignores the alloc
    wv = 2'b11; wt[0] = TW'(20); wt[1] = TW'(20);
    wd[0] = 32'h1111; wd[1] = 32'hABCD; av = 1'b1; at = TW'(20);
    ra[0] = TW'(20); ra[1] = TW'(0);
    #1;
`ifdef PRF_BYPASS_EN
    exp_d = 32'hABCD; exp_r = 1'b1;
`else
    exp_d = 32'h1234; exp_r = 1'b1;
`endif
    chk("bypass prio rd_data[0]", rdd[0], exp_d);
    chk("bypass prio rd_ready[0]", DW'(rdy[0]), DW'(exp_r));
    tick();
    idle_inputs();
    #1;
    chk("alloc+collide rd_data[0]", rdd[0], 32'hABCD);
    chk("alloc+collide rd_ready[0]", DW'(rdy[0]), 32'd0);
    chk("alloc+collide wr_conflict", DW'(conf), 32'd1);
    tick();
    chk("conflict one cycle", DW'(conf), 32'd0);

    // Randomized traffic against the model; narrow tags force collisions
    for (int c = 0; c < 600; c++) begin
      rst   = ($urandom_range(63) == 0);
      wv    = NW'($urandom);
      for (int j = 0; j < int'(NW); j++) begin
        wt[j] = ($urandom_range(3) == 0) ? TW'($urandom) : TW'($urandom_range(7));
        wd[j] = $urandom;
      end
      av = ($urandom_range(2) == 0);
      at = TW'($urandom_range(7));
      for (int i = 0; i < int'(NR); i++)
        ra[i] = ($urandom_range(3) == 0) ? TW'($urandom) : TW'($urandom_range(7));
      #1;
      chk_model_reads($sformatf("rand%0d", c));
      tick();
      chk($sformatf("rand%0d wr_conflict", c), DW'(conf), DW'(m_conf));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prf_multiport.md
Name: prf_multiport

Overview:
- Next-generation physical register file for the out-of-order core, with parametrised depth, width, read-port count and CDB write-port count.
- Tracks a per-register ready bit: set on CDB writeback, cleared on rename allocation. Issue logic reads operand data and readiness together.
- Sits between rename (allocation), the issue queue (operand reads) and the CDB (writeback).

Parameters:
- NUM_PREGS, 64, number of physical registers; power of two, at least 2.
- DATA_W, 32, register width in bits.
- NUM_RD, 2, number of combinational read ports.
- NUM_WR, 2, number of CDB write ports.
- TAG_W, $clog2(NUM_PREGS), physical tag width (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- rd_addr  in  NUM_RD*TAG_W  read tags; port i occupies slice [i*TAG_W +: TAG_W].
- rd_data  out  NUM_RD*DATA_W  read data per port.
- rd_ready  out  NUM_RD  ready bit of the addressed register.
- wr_valid  in  NUM_WR  CDB write enables.
- wr_tag  in  NUM_WR*TAG_W  CDB destination tags.
- wr_data  in  NUM_WR*DATA_W  CDB result data.
- alloc_valid  in  1  rename allocates a destination register this cycle.
- alloc_tag  in  TAG_W  tag being allocated.
- wr_conflict  out  1  registered flag: two or more write ports hit the same nonzero tag in the previous cycle.

Behaviour:
- Reset (rst high at a posedge):
  - All data words become 0 and all ready bits become 1.
  - wr_conflict becomes 0.
  - Reset overrides every write and alloc presented in the same cycle.
  - Reset asserted mid-stream discards all in-flight state; the cycle after rst deasserts behaves as a fresh start.
- Register p0:
  - Hardwired: reads always return data 0 with ready 1.
  - Writes and allocs targeting p0 are ignored.
- Writes:
  - At a posedge with wr_valid[j]=1: data[wr_tag[j]] <= wr_data[j] and ready[wr_tag[j]] <= 1.
  - Same-tag collision between ports: the highest-indexed port wins. wr_conflict is 1 in the following cycle only.
- Alloc:
  - At a posedge with alloc_valid=1: ready[alloc_tag] <= 0. Data is unchanged.
  - Alloc and write to the same tag in the same cycle: data is written; ready ends at 0 (alloc has priority on the ready bit).
- Reads:
  - Purely combinational from the current array state.
  - With bypass compiled out, a write in cycle N is visible to reads in cycle N+1.
  - Any number of read ports may address the same tag.
- Latency:
  - Write to readable: 1 cycle, or 0 cycles with bypass.
  - Alloc to ready=0 visible: 1 cycle.
- Tag range: tags are unsigned, and NUM_PREGS is a power of two, so every tag value is in range and there is no out-of-range case.

Optional Feature:
- Macro: PRF_BYPASS_EN.
- Defined:
  - Each read port compares rd_addr against every wr_tag with wr_valid set in the same cycle.
  - On a match to a nonzero tag, rd_data is the forwarded wr_data and rd_ready is 1.
  - When several ports match, the highest-indexed write port is forwarded, consistent with write priority.
  - Bypass ignores a same-cycle alloc.
- Undefined: no forwarding; reads see the array state only.

Decomposition:
- Shared package prf_pkg holds:
  - default localparams for NUM_PREGS, DATA_W and TAG_W;
  - the typedef ptag_t (logic [TAG_W-1:0]);
  - the typedef pdata_t;
  - the constant PREG_ZERO = 0.
- One sub-module, prf_wr_arbiter: a combinational per-register highest-index write select that produces the per-register write enable, selected data and the conflict detect. It is reused by the bypass mux.

Test Plan:
- Reset then read: assert rst 1 cycle; read tags 0, 5 and 63 -> rd_data 0, rd_ready 1 on all ports.
- Alloc/writeback:
  - alloc tag 7 -> next cycle rd_ready=0 for tag 7.
  - CDB port0 writes tag 7 = 0xDEADBEEF -> next cycle data 0xDEADBEEF, ready 1.
- Write collision: port0 and port1 both write tag 9 (0x11, 0x22) -> tag 9 = 0x22; wr_conflict=1 for exactly one cycle.
- p0 protection: write tag 0 = 0xFFFFFFFF and alloc tag 0 -> reads of tag 0 return 0, ready 1.
- Alloc+write same cycle on tag 12 with data 0x5A -> data 0x5A, ready 0. With PRF_BYPASS_EN: same-cycle read of a written tag 20 = 0x1234 returns 0x1234, ready 1; without the macro it returns the old value.
- Mid-stream reset: writes on both ports plus alloc, with rst high in the same cycle -> all registers 0 and ready, wr_conflict 0.
